// File: rtl/vga_timing.sv
// vga_timing: pixel/line counters with a registered decode of coordinates,
// active-area enable, syncs and start-of-line/frame strobes.
// Optional macro VGA_TIMING_FRAME_CNT_EN enables the 16-bit frame counter;
// without it frame_cnt is tied to zero.
module vga_timing #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce,
   output logic [10:0] x,
   output logic [10:0] y,
   output logic        de,
   output logic        hs,
   output logic        vs,
   output logic        line_start,
   output logic        frame_start,
   output logic [15:0] frame_cnt
);

   localparam int unsigned CW       = 11;
   localparam int unsigned FCW      = 16;
   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_START = H_ACTIVE + H_FP;
   localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
   localparam int unsigned VS_START = V_ACTIVE + V_FP;
   localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;

   // Totals must fit the 11-bit counters
   if (H_TOTAL > 2047) begin : g_h_total_chk
      $error("vga_timing: H_TOTAL exceeds 2047");
   end
   if (V_TOTAL > 2047) begin : g_v_total_chk
      $error("vga_timing: V_TOTAL exceeds 2047");
   end

   logic [CW-1:0] hc_q, hc_d;
   logic [CW-1:0] vc_q, vc_d;
   logic [CW-1:0] x_q, x_d;
   logic [CW-1:0] y_q, y_d;
   logic          de_q, de_d;
   logic          hs_q, hs_d;
   logic          vs_q, vs_d;
   logic          line_start_q, line_start_d;
   logic          frame_start_q, frame_start_d;

   logic          h_last;
   logic          v_last;
   logic          in_hsync;
   logic          in_vsync;

   // Counter advance and decode of the pre-increment position
   always_comb begin
      hc_d          = hc_q;
      vc_d          = vc_q;
      x_d           = x_q;
      y_d           = y_q;
      de_d          = de_q;
      hs_d          = hs_q;
      vs_d          = vs_q;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;

      h_last   = (hc_q == CW'(H_TOTAL - 1));
      v_last   = (vc_q == CW'(V_TOTAL - 1));
      in_hsync = (hc_q >= CW'(HS_START)) && (hc_q < CW'(HS_END));
      in_vsync = (vc_q >= CW'(VS_START)) && (vc_q < CW'(VS_END));

      if (ce) begin
         x_d           = hc_q;
         y_d           = vc_q;
         de_d          = (hc_q < CW'(H_ACTIVE)) && (vc_q < CW'(V_ACTIVE));
         hs_d          = in_hsync ? HS_POL : ~HS_POL;
         vs_d          = in_vsync ? VS_POL : ~VS_POL;
         line_start_d  = (hc_q == '0);
         frame_start_d = (hc_q == '0) && (vc_q == '0);

         if (h_last) begin
            hc_d = '0;
            vc_d = v_last ? '0 : vc_q + CW'(1);
         end else begin
            hc_d = hc_q + CW'(1);
         end
      end
   end

   // State and output registers; reset wins over ce
   always_ff @(posedge clk) begin
      if (rst) begin
         hc_q          <= '0;
         vc_q          <= '0;
         x_q           <= '0;
         y_q           <= '0;
         de_q          <= 1'b0;
         hs_q          <= ~HS_POL;
         vs_q          <= ~VS_POL;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         hc_q          <= hc_d;
         vc_q          <= vc_d;
         x_q           <= x_d;
         y_q           <= y_d;
         de_q          <= de_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [FCW-1:0] frame_cnt_q, frame_cnt_d;

   // Count frames on the same edge that raises frame_start
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      if (frame_start_d) begin
         frame_cnt_d = frame_cnt_q + FCW'(1);
      end
   end

   // Frame counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt_q <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign frame_cnt = frame_cnt_q;
`else
   assign frame_cnt = FCW'(0);
`endif

   assign x           = x_q;
   assign y           = y_q;
   assign de          = de_q;
   assign hs          = hs_q;
   assign vs          = vs_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: directed bench for vga_timing. A default-timing instance
// covers line-level behaviour; a shrunk instance (18x12 total, active-high
// syncs) covers frame-level behaviour within a short run.
module tb_vga_timing;

   logic        clk;
   logic        rst;
   logic        ce;

   logic [10:0] d_x, d_y, s_x, s_y;
   logic        d_de, d_hs, d_vs, d_ls, d_fs;
   logic        s_de, s_hs, s_vs, s_ls, s_fs;
   logic [15:0] d_fc, s_fc;

   int total;
   int bad;
   int p;        // index of last loaded pixel since reset release, -1 = reset state
   bit pulse;    // last edge was a ce=1 edge out of reset

   vga_timing dut (
      .clk(clk), .rst(rst), .ce(ce),
      .x(d_x), .y(d_y), .de(d_de), .hs(d_hs), .vs(d_vs),
      .line_start(d_ls), .frame_start(d_fs), .frame_cnt(d_fc)
   );

   // H: 10 active, fp 2, sync 3, bp 3 -> 18; V: 6, 2, 2, 2 -> 12; frame 216
   vga_timing #(
      .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(6),  .V_FP(2), .V_SYNC(2), .V_BP(2),
      .HS_POL(1'b1), .VS_POL(1'b1)
   ) dut_s (
      .clk(clk), .rst(rst), .ce(ce),
      .x(s_x), .y(s_y), .de(s_de), .hs(s_hs), .vs(s_vs),
      .line_start(s_ls), .frame_start(s_fs), .frame_cnt(s_fc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s p=%0d observed=%0h expected=%0h", tag, p, obs, exp);
      end
   endtask

   // Expected outputs of both instances from the pixel index p
   task automatic check_all();
      int hx, vy, fc;
      if (p < 0) begin
         check("d.x", 32'(d_x), 0);   check("d.y", 32'(d_y), 0);
         check("d.de", 32'(d_de), 0); check("d.hs", 32'(d_hs), 1);
         check("d.vs", 32'(d_vs), 1); check("d.ls", 32'(d_ls), 0);
         check("d.fs", 32'(d_fs), 0); check("d.fc", 32'(d_fc), 0);
         check("s.x", 32'(s_x), 0);   check("s.y", 32'(s_y), 0);
         check("s.de", 32'(s_de), 0); check("s.hs", 32'(s_hs), 0);
         check("s.vs", 32'(s_vs), 0); check("s.ls", 32'(s_ls), 0);
         check("s.fs", 32'(s_fs), 0); check("s.fc", 32'(s_fc), 0);
      end else begin
         hx = p % 800;
         vy = (p / 800) % 525;
`ifdef VGA_TIMING_FRAME_CNT_EN
         fc = (p / 420000) + 1;
`else
         fc = 0;
`endif
         check("d.x", 32'(d_x), hx);
         check("d.y", 32'(d_y), vy);
         check("d.de", 32'(d_de), (hx < 640 && vy < 480) ? 1 : 0);
         check("d.hs", 32'(d_hs), (hx >= 656 && hx < 752) ? 0 : 1);
         check("d.vs", 32'(d_vs), (vy >= 490 && vy < 492) ? 0 : 1);
         check("d.ls", 32'(d_ls), (pulse && hx == 0) ? 1 : 0);
         check("d.fs", 32'(d_fs), (pulse && hx == 0 && vy == 0) ? 1 : 0);
         check("d.fc", 32'(d_fc), fc);

         hx = p % 18;
         vy = (p / 18) % 12;
`ifdef VGA_TIMING_FRAME_CNT_EN
         fc = (p / 216) + 1;
`else
         fc = 0;
`endif
         check("s.x", 32'(s_x), hx);
         check("s.y", 32'(s_y), vy);
         check("s.de", 32'(s_de), (hx < 10 && vy < 6) ? 1 : 0);
         check("s.hs", 32'(s_hs), (hx >= 12 && hx < 15) ? 1 : 0);
         check("s.vs", 32'(s_vs), (vy >= 8 && vy < 10) ? 1 : 0);
         check("s.ls", 32'(s_ls), (pulse && hx == 0) ? 1 : 0);
         check("s.fs", 32'(s_fs), (pulse && hx == 0 && vy == 0) ? 1 : 0);
         check("s.fc", 32'(s_fc), fc);
      end
   endtask

   // Drive one clk with the given rst/ce, sample 1 time unit after the edge
   task automatic step(input logic r, input logic c);
      rst = r;
      ce  = c;
      @(posedge clk);
      #1;
      if (r) begin
         p     = -1;
         pulse = 1'b0;
      end else if (c) begin
         p     = p + 1;
         pulse = 1'b1;
      end else begin
         pulse = 1'b0;
      end
      check_all();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      p     = -1;
      pulse = 1'b0;
      rst   = 1'b1;
      ce    = 1'b0;

      // Reset state
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);

      // First pixel after release
      step(1'b0, 1'b1);
      check("first.x", 32'(d_x), 0);
      check("first.de", 32'(d_de), 1);
      check("first.fs", 32'(d_fs), 1);
      check("first.ls", 32'(d_ls), 1);

      // Full default line, plus start of the next one 800 cycles later
      for (int i = 0; i < 800; i++) begin
         step(1'b0, 1'b1);
         if (p == 639) check("de.last_active", 32'(d_de), 1);
         if (p == 640) check("de.first_blank", 32'(d_de), 0);
         if (p == 656) check("hs.first", 32'(d_hs), 0);
         if (p == 751) check("hs.last", 32'(d_hs), 0);
         if (p == 752) check("hs.after", 32'(d_hs), 1);
      end
      check("line2.x", 32'(d_x), 0);
      check("line2.y", 32'(d_y), 1);
      check("line2.ls", 32'(d_ls), 1);
      check("line2.fs", 32'(d_fs), 0);

      // ce toggling: outputs hold while ce=0, strobes stay one clk wide
      for (int i = 0; i < 80; i++) begin
         step(1'b0, 1'b0);
         step(1'b0, 1'b1);
      end

      // Run until the small instance sits in both syncs (x=13, y=8)
      for (int i = 0; i < 400 && (p % 216) != 157; i++) begin
         step(1'b0, 1'b1);
      end
      check("mid.s.x", 32'(s_x), 13);
      check("mid.s.y", 32'(s_y), 8);
      check("mid.s.hs", 32'(s_hs), 1);
      check("mid.s.vs", 32'(s_vs), 1);

      // Reset mid-frame with ce=1: reset wins, no sync held over
      step(1'b1, 1'b1);
      check("rst.s.hs", 32'(s_hs), 0);
      check("rst.s.vs", 32'(s_vs), 0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      check("restart.s.fs", 32'(s_fs), 1);
      check("restart.d.fs", 32'(d_fs), 1);

      // Three-plus small frames: vs, y wrap 11->0, frame_start, frame_cnt
      for (int i = 0; i < 3 * 216; i++) begin
         step(1'b0, 1'b1);
         if (p == 215) check("wrap.s.y_last", 32'(s_y), 11);
         if (p == 216) check("wrap.s.fs", 32'(s_fs), 1);
         if (p == 432) begin
`ifdef VGA_TIMING_FRAME_CNT_EN
            check("fc3.s", 32'(s_fc), 3);
`else
            check("fc3.s", 32'(s_fc), 0);
`endif
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- HS_POL, 0, hs active level
- VS_POL, 0, vs active level

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single system clock; all logic on its rising edge
- rst, in, 1, reset; synchronous and active-high
- ce, in, 1, pixel strobe; one pixel advance per clk cycle with ce=1
- x, out, 11, pixel column of the current output pixel
- y, out, 11, line number of the current output pixel
- de, out, 1, 1 while (x,y) is inside the active area
- hs, out, 1, horizontal sync at HS_POL level when active
- vs, out, 1, vertical sync at VS_POL level when active
- line_start, out, 1, one-clk pulse when x becomes 0
- frame_start, out, 1, one-clk pulse when (x,y) becomes (0,0)
- frame_cnt, out, 16, frame counter (see Configuration)

REQ-003 x and y SHALL be the coordinate inputs of the downstream button/overlay stages; both SHALL be 11 bits.

Function
REQ-004 H_TOTAL SHALL be H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default), and V_TOTAL SHALL be V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default).
REQ-005 Both totals SHALL be at most 2047; a violation SHALL be an elaboration error.
REQ-006 Internal counters hc (0..H_TOTAL-1) and vc (0..V_TOTAL-1) SHALL change only in cycles where ce=1.
REQ-007 On ce=1, hc SHALL increment; at hc=H_TOTAL-1, hc SHALL wrap to 0 and vc SHALL increment.
REQ-008 vc SHALL wrap to 0 when it is at V_TOTAL-1 and hc wraps.
REQ-009 On each ce=1, the output registers SHALL load the decode of the pre-increment hc/vc, so outputs lag the counters by exactly one ce:
- x=hc, y=vc
- de = (hc<H_ACTIVE) and (vc<V_ACTIVE)
- hs = HS_POL when H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC, else the inverse of HS_POL
- vs = VS_POL when V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC, else the inverse of VS_POL; vs timing is per line, independent of hc
REQ-010 x, y, de, hs and vs SHALL hold their values in cycles where ce=0.
REQ-011 line_start SHALL be 1 for exactly the one clk cycle after a ce that loads x=0, and 0 otherwise, including while ce stays 0.
REQ-012 frame_start SHALL behave the same way for a ce that loads x=0 and y=0; line_start SHALL also be 1 in that cycle.
REQ-013 If ce is held at 1, one line SHALL be H_TOTAL clk cycles and one frame SHALL be H_TOTAL*V_TOTAL clk cycles (420000 by default).
REQ-014 There SHALL be no ready/valid handshake; downstream stages SHALL sample x/y/de in the same cycle they are presented.

Reset
REQ-015 When rst=1 at a clk edge, the block SHALL set, regardless of ce:
- hc=0, vc=0
- x=0, y=0, de=0
- hs = inverse of HS_POL, vs = inverse of VS_POL
- line_start=0, frame_start=0, frame_cnt=0
REQ-016 The first ce=1 after rst is released SHALL load x=0, y=0, de=1, and SHALL pulse line_start and frame_start.
REQ-017 rst asserted mid-frame SHALL abort the frame with no partial sync pulse held over, and SHALL restart per REQ-016.
REQ-018 rst SHALL take priority over ce in the same cycle.

Configuration
REQ-019 With the macro VGA_TIMING_FRAME_CNT_EN defined, frame_cnt SHALL increment by 1 in the cycle frame_start is 1, wrapping 65535 to 0.
REQ-020 Without VGA_TIMING_FRAME_CNT_EN, frame_cnt SHALL be the constant 0, and no counter logic for it SHALL be synthesised.
REQ-021 All other behaviour SHALL be identical with and without the macro.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Defaults, ce=1, rst pulse -> first pixel x=0,y=0,de=1, frame_start=1; next frame_start exactly 420000 cycles later.
- ce=1, line 0 -> de falls when x goes 639->640; hs=0 for x=656..751; line_start period is 800 cycles.
- ce=1, full frame -> vs=0 for y=490..491; de=0 for y>=480; y wraps 524->0 with frame_start.
- ce toggling 1,0,1,0 -> x advances once per 2 clk; line_start/frame_start still one clk wide; outputs hold while ce=0.
- rst=1 at x=300,y=200, hs/vs mid-frame -> next cycle all outputs at reset values; first ce after release gives x=0,y=0.
- With macro defined, 3 frames run -> frame_cnt=3; without the macro -> frame_cnt stays 0.
